serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: diff = a - b, computed LSB-first, one bit per clock.

---
 rtl/serial_subtractor_if.sv | 16 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bOut;
  logic         ovf;

  modport master (output start, a, b, input busy, done, diff, bOut, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bOut, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b), LSB first, one full-adder cell:
// b is inverted and the carry is preset to 1 on load.
module serial_subtractor #(
  parameter int W = 8
) (
  input logic                clk,
  input logic                rstN,
  serial_subtractor_if.slave bus
);
  localparam int CntW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT          state;
  logic [CntW-1:0] cnt;
  logic [W-1:0]   aSh;
  logic [W-1:0]   bSh;
  logic [W-1:0]   work;
  logic           carry;
  logic           aMsb;
  logic           bMsb;
  logic           busyR;
  logic           doneR;
  logic [W-1:0]   diffR;
  logic           bOutR;
  logic           ovfR;

  logic           bitS;
  logic           carryNext;
  logic [W-1:0]   workNext;

  always_comb begin
    bitS      = aSh[0] ^ ~bSh[0] ^ carry;
    carryNext = (aSh[0] & ~bSh[0]) | (aSh[0] & carry) | (~bSh[0] & carry);
    workNext  = {bitS, work[W-1:1]};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= '0;
      aSh   <= '0;
      bSh   <= '0;
      work  <= '0;
      carry <= 1'b0;
      aMsb  <= 1'b0;
      bMsb  <= 1'b0;
      busyR <= 1'b0;
      doneR <= 1'b0;
      diffR <= '0;
      bOutR <= 1'b0;
      ovfR  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          doneR <= 1'b0;
          if (bus.start) begin
            aSh   <= bus.a;
            bSh   <= bus.b;
            aMsb  <= bus.a[W-1];
            bMsb  <= bus.b[W-1];
            carry <= 1'b1;
            cnt   <= '0;
            work  <= '0;
            busyR <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          aSh   <= aSh >> 1;
          bSh   <= bSh >> 1;
          carry <= carryNext;
          work  <= workNext;
          cnt   <= cnt + CntW'(1);
          // Results are taken from the next-state values so they land on the Wth edge.
          if (cnt == CntW'(W - 1)) begin
            state <= DONE;
            busyR <= 1'b0;
            doneR <= 1'b1;
            diffR <= workNext;
            bOutR <= ~carryNext;
            ovfR  <= (aMsb != bMsb) && (workNext[W-1] != aMsb);
          end
        end
        default: begin
          state <= IDLE;
          busyR <= 1'b0;
          doneR <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busyR;
  assign bus.done = doneR;
  assign bus.diff = diffR;
  assign bus.bOut = bOutR;
  assign bus.ovf  = ovfR;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor at W=4 (directed + exhaustive) and W=8 (corners + random).
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  serial_subtractor_if #(.W(4)) if4 ();
  serial_subtractor_if #(.W(8)) if8 ();

  serial_subtractor #(.W(4)) dut4 (.clk(clk), .rstN(rstN), .bus(if4));
  serial_subtractor #(.W(8)) dut8 (.clk(clk), .rstN(rstN), .bus(if8));

  typedef struct {
    logic [7:0] diff;
    logic       bOut;
    logic       ovf;
  } expT;

  expT q4[$];
  expT q8[$];
  int  checks   = 0;
  int  failures = 0;
  int  starts4  = 0;
  int  starts8  = 0;
  int  doneCnt4 = 0;
  int  doneCnt8 = 0;

  function automatic expT model(input int unsigned w, input logic [7:0] a, input logic [7:0] b);
    expT        e;
    logic [8:0] mask;
    logic [7:0] am;
    logic [7:0] bm;
    logic [7:0] d;
    mask   = (9'd1 << w) - 9'd1;
    am     = a & mask[7:0];
    bm     = b & mask[7:0];
    d      = (am - bm) & mask[7:0];
    e.diff = d;
    e.bOut = (am < bm);
    e.ovf  = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every done pops one expectation.
  always @(negedge clk) begin
    expT e;
    if (if4.done === 1'b1) begin
      doneCnt4++;
      chk("sb4_nonempty", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("diff4", 32'(if4.diff), 32'(e.diff[3:0]));
        chk("bOut4", 32'(if4.bOut), 32'(e.bOut));
        chk("ovf4", 32'(if4.ovf), 32'(e.ovf));
      end
    end
    if (if8.done === 1'b1) begin
      doneCnt8++;
      chk("sb8_nonempty", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("diff8", 32'(if8.diff), 32'(e.diff));
        chk("bOut8", 32'(if8.bOut), 32'(e.bOut));
        chk("ovf8", 32'(if8.ovf), 32'(e.ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int n;
    if4.a = a; if4.b = b; if4.start = 1'b1;
    q4.push_back(model(4, {4'd0, a}, {4'd0, b}));
    starts4++;
    @(negedge clk);
    if4.start = 1'b0;
    n = 0;
    while (if4.done !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    chk("done4_timeout", 32'(if4.done), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n;
    if8.a = a; if8.b = b; if8.start = 1'b1;
    q8.push_back(model(8, a, b));
    starts8++;
    @(negedge clk);
    if8.start = 1'b0;
    n = 0;
    while (if8.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("done8_timeout", 32'(if8.done), 32'd1);
  endtask

  initial begin
    logic [7:0] corner [7][2];
    rstN = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_done", 32'(if4.done), 32'd0);
    chk("rst_diff", 32'(if4.diff), 32'd0);
    chk("rst_bOut", 32'(if4.bOut), 32'd0);
    chk("rst_ovf", 32'(if4.ovf), 32'd0);
    chk("rst_busy8", 32'(if8.busy), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // 5 - 3: busy for four cycles, done in the fifth, one-cycle pulse.
    if4.a = 4'd5; if4.b = 4'd3; if4.start = 1'b1;
    q4.push_back(model(4, 8'd5, 8'd3)); starts4++;
    @(negedge clk);
    if4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy", 32'(if4.busy), 32'd1);
      chk("t1_done_early", 32'(if4.done), 32'd0);
      @(negedge clk);
    end
    chk("t1_done", 32'(if4.done), 32'd1);
    chk("t1_busy_off", 32'(if4.busy), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(if4.done), 32'd0);

    // 3 - 5, and diff must hold its old value throughout RUN.
    if4.a = 4'd3; if4.b = 4'd5; if4.start = 1'b1;
    q4.push_back(model(4, 8'd3, 8'd5)); starts4++;
    @(negedge clk);
    if4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_diff_hold", 32'(if4.diff), 32'd2);
      @(negedge clk);
    end
    chk("t2_done", 32'(if4.done), 32'd1);
    @(negedge clk);

    // Signed overflow cases.
    op4(4'b1000, 4'd1);
    op4(4'd7, 4'b1111);
    @(negedge clk);

    // start held high, operands scrambled during RUN, back-to-back accept in DONE.
    if4.a = 4'd5; if4.b = 4'd3; if4.start = 1'b1;
    q4.push_back(model(4, 8'd5, 8'd3)); starts4++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if4.a = 4'($urandom); if4.b = 4'($urandom);
    end
    @(negedge clk);
    chk("t4_done_a", 32'(if4.done), 32'd1);
    if4.a = 4'd9; if4.b = 4'd2;
    q4.push_back(model(4, 8'd9, 8'd2)); starts4++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if4.a = 4'($urandom); if4.b = 4'($urandom);
      chk("t4_done_gap", 32'(if4.done), 32'd0);
    end
    @(negedge clk);
    chk("t4_done_b", 32'(if4.done), 32'd1);
    if4.start = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(if4.busy | if4.done), 32'd0);

    // Reset mid-RUN: outputs clear asynchronously, no done follows.
    if4.a = 4'd6; if4.b = 4'd1; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    chk("t5_busy_pre", 32'(if4.busy), 32'd1);
    rstN = 1'b0;
    #1;
    chk("t5_busy", 32'(if4.busy), 32'd0);
    chk("t5_done", 32'(if4.done), 32'd0);
    chk("t5_diff", 32'(if4.diff), 32'd0);
    chk("t5_bOut", 32'(if4.bOut), 32'd0);
    chk("t5_ovf", 32'(if4.ovf), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(if4.done), 32'd0);
    end
    op4(4'd6, 4'd1);
    @(negedge clk);

    // Exhaustive W=4.
    for (int unsigned x = 0; x < 16; x++)
      for (int unsigned y = 0; y < 16; y++)
        op4(4'(x), 4'(y));
    @(negedge clk);

    // W=8 corners then random pairs.
    corner = '{'{8'd0, 8'd0}, '{8'd255, 8'd0}, '{8'd0, 8'd255}, '{8'd128, 8'd1},
               '{8'd127, 8'd255}, '{8'd128, 8'd128}, '{8'd127, 8'd128}};
    for (int i = 0; i < 7; i++) op8(corner[i][0], corner[i][1]);
    for (int i = 0; i < 1500; i++) op8(8'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);

    chk("done_count4", 32'(doneCnt4), 32'(starts4));
    chk("done_count8", 32'(doneCnt8), 32'(starts8));
    chk("sb4_drained", 32'(q4.size()), 32'd0);
    chk("sb8_drained", 32'(q8.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
